instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, the instruction-memory word-address width (depth 2**ADDR_W).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, field bundle valid.
REQ-005 The block SHALL have port in_ready, output, 1, block accepts a bundle this cycle.
REQ-006 The block SHALL have port fmt, input, 3, format select: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J.
REQ-007 The block SHALL have ports op (7), funct3 (3), funct7b5 (1), rd (5), rs1 (5) and rs2 (5), all inputs, carrying the RV32I instruction fields.
REQ-008 The block SHALL have port imm, input, 32, the sign-extended immediate value; byte offset for B and J.
REQ-009 The block SHALL have port clear, input, 1, synchronous write-pointer clear.
REQ-010 The block SHALL have ports mem_we (output, 1), mem_addr (output, ADDR_W) and mem_wdata (output, 32) forming the instruction-memory write port.
REQ-011 The block SHALL have ports count (output, ADDR_W+1), words written, and full (output, 1), memory full.
REQ-012 The block SHALL have port err, output, 1, one-cycle pulse when a bundle is rejected.

Function
REQ-013 The FSM SHALL have states IDLE, ENC and WR.
REQ-014 FSM transitions: IDLE->ENC on in_valid & in_ready; ENC->WR unconditionally; WR->IDLE unconditionally.
REQ-015 in_ready SHALL be 1 only in IDLE with full=0 and clear=0.
REQ-016 On acceptance all fields SHALL be registered; later input changes SHALL have no effect on that bundle.
REQ-017 In ENC the registered 32-bit word SHALL be formed by format: R {funct7b5?0100000:0000000, rs2, rs1, funct3, rd, op}; I {imm[11:0], rs1, funct3, rd, op}; S {imm[11:5], rs2, rs1, funct3, imm[4:0], op}; B {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}; U {imm[31:12], rd, op}; J {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
REQ-018 For I format with op=0010011 and funct3 of 001 or 101, bits [31:25] SHALL be {0, funct7b5, 00000} and bits [24:20] SHALL be imm[4:0].
REQ-019 In WR mem_we SHALL be 1 for exactly one cycle, with mem_addr equal to the current write pointer and mem_wdata equal to the encoded word.
REQ-020 mem_we SHALL rise exactly 2 cycles after the acceptance edge, giving a throughput of one word per 3 cycles.
REQ-021 After a WR write the pointer and count SHALL each increment by 1.
REQ-022 full SHALL equal (count == 2**ADDR_W); the pointer SHALL NOT wrap, and no write SHALL occur while full.
REQ-023 clear SHALL have priority over all other actions: pointer=0, count=0, state=IDLE; an in-flight bundle SHALL be aborted with no mem_we and no err.
REQ-024 mem_we, err, mem_addr and mem_wdata SHALL be 0 whenever the block is not in WR.

Reset
REQ-025 While reset_n=0 the block SHALL force state=IDLE, pointer=0, count=0, mem_we=0, err=0 and mem_wdata=0, with in_ready=0 until reset_n=1.
REQ-026 Reset asserted in ENC or WR SHALL abort the bundle immediately with no write.

Configuration
REQ-027 When ILLEGAL_CHK_EN is defined, a bundle SHALL be illegal if any of the following holds: fmt>5; I or S imm outside -2048..2047; B imm odd or outside -4096..4094; J imm odd or outside -1048576..1048574; U imm[11:0]!=0; or a shift with imm>31.
REQ-028 An illegal bundle SHALL, in its WR cycle, pulse err=1 with mem_we=0 and leave the pointer and count unchanged.
REQ-029 When ILLEGAL_CHK_EN is undefined, err SHALL be tied 0, fields SHALL be truncated per REQ-017, and fmt>5 SHALL encode as R.

Verification
REQ-030 Scenario: I, op=0010011, funct3=000, rd=1, rs1=0, imm=5 -> mem_wdata=0x00500093 at mem_addr=0, mem_we 2 cycles after accept, count=1.
REQ-031 Scenario: R, op=0110011, rd=3, rs1=1, rs2=2, funct7b5=0 then funct7b5=1 -> 0x002081B3 at addr 0, then 0x402081B3 at addr 1.
REQ-032 Scenario: B, op=1100011, funct3=000, rs1=1, rs2=2, imm=8 -> 0x00208463; then J, op=1101111, rd=1, imm=16 -> 0x010000EF.
REQ-033 Scenario: ADDR_W=2, 4 bundles -> full=1, count=4, in_ready=0; a fifth in_valid is not accepted; clear -> count=0, full=0, in_ready=1.
REQ-034 Scenario: reset_n low during ENC -> no mem_we, count=0; clear during WR -> no mem_we.
REQ-035 Scenario (ILLEGAL_CHK_EN defined): I with imm=4096 -> err pulse, mem_we=0, count unchanged.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: accepts a field bundle, encodes it, writes one word per 3 cycles
// into instruction memory. Optional ILLEGAL_CHK_EN enables illegal-bundle rejection via err.
module instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  input  logic              clear,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ENC, WR} state_t;

  localparam int unsigned        DEPTH_I = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]    DEPTH   = DEPTH_I[ADDR_W:0];
  localparam logic [ADDR_W-1:0]  PTR_MAX = '1;

  state_t              r_state;
  state_t              w_state_next;
  logic [2:0]          r_fmt;
  logic [6:0]          r_op;
  logic [2:0]          r_funct3;
  logic                r_funct7b5;
  logic [4:0]          r_rd;
  logic [4:0]          r_rs1;
  logic [4:0]          r_rs2;
  logic [31:0]         r_imm;
  logic [31:0]         r_word;
  logic                r_illegal;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_count;
  logic [31:0]         w_word;
  logic                w_illegal;
  logic                w_shift;
  logic                w_accept;
  logic                w_write;
  logic                w_in_wr;

  assign full     = (r_count == DEPTH);
  assign count    = r_count;
  assign in_ready = reset_n && (r_state == IDLE) && !full && !clear;
  assign w_accept = in_valid && in_ready;
  assign w_in_wr  = (r_state == WR);

  // clear acts combinationally so a write or err in the clearing cycle is suppressed
  assign w_write   = w_in_wr && !r_illegal && !full && !clear;
  assign mem_we    = w_write;
  assign err       = w_in_wr && r_illegal && !clear;
  assign mem_addr  = w_in_wr ? r_ptr  : '0;
  assign mem_wdata = w_in_wr ? r_word : '0;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = ENC;
      ENC:     w_state_next = WR;
      WR:      w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (clear) w_state_next = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fmt      <= '0;
      r_op       <= '0;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_imm      <= '0;
    end else if (w_accept) begin
      r_fmt      <= fmt;
      r_op       <= op;
      r_funct3   <= funct3;
      r_funct7b5 <= funct7b5;
      r_rd       <= rd;
      r_rs1      <= rs1;
      r_rs2      <= rs2;
      r_imm      <= imm;
    end
  end

  assign w_shift = (r_fmt == 3'd1) && (r_op == 7'b0010011) &&
                   ((r_funct3 == 3'b001) || (r_funct3 == 3'b101));

  always_comb begin
    w_word = '0;
    case (r_fmt)
      3'd1: begin
        if (w_shift)
          w_word = {1'b0, r_funct7b5, 5'b00000, r_imm[4:0], r_rs1, r_funct3, r_rd, r_op};
        else
          w_word = {r_imm[11:0], r_rs1, r_funct3, r_rd, r_op};
      end
      3'd2: w_word = {r_imm[11:5], r_rs2, r_rs1, r_funct3, r_imm[4:0], r_op};
      3'd3: w_word = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_funct3,
                      r_imm[4:1], r_imm[11], r_op};
      3'd4: w_word = {r_imm[31:12], r_rd, r_op};
      3'd5: w_word = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, r_op};
      default: w_word = {1'b0, r_funct7b5, 5'b00000, r_rs2, r_rs1, r_funct3, r_rd, r_op};
    endcase
  end

`ifdef ILLEGAL_CHK_EN
  always_comb begin
    w_illegal = 1'b0;
    case (r_fmt)
      3'd0: w_illegal = 1'b0;
      3'd1, 3'd2:
        w_illegal = ($signed(r_imm) < -32'sd2048) || ($signed(r_imm) > 32'sd2047);
      3'd3:
        w_illegal = r_imm[0] || ($signed(r_imm) < -32'sd4096) ||
                    ($signed(r_imm) > 32'sd4094);
      3'd4: w_illegal = (r_imm[11:0] != 12'd0);
      3'd5:
        w_illegal = r_imm[0] || ($signed(r_imm) < -32'sd1048576) ||
                    ($signed(r_imm) > 32'sd1048574);
      default: w_illegal = 1'b1;
    endcase
    // shift amounts are treated as unsigned, so negative values are rejected too
    if (w_shift && (r_imm > 32'd31)) w_illegal = 1'b1;
  end
`else
  assign w_illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word    <= '0;
      r_illegal <= 1'b0;
    end else if (r_state == ENC) begin
      r_word    <= w_word;
      r_illegal <= w_illegal;
    end
  end

  // pointer saturates at the last address instead of wrapping once full
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_write) begin
      r_count <= r_count + 1'b1;
      if (r_ptr != PTR_MAX) r_ptr <= r_ptr + 1'b1;
    end
  end

endmodule
